data_memory_dumper: RTL

DATA_MEMORY_DUMPER -- requirements
Module: data_memory_dumper

---
 rtl/data_memory_dumper.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_dumper.sv
// data_memory_dumper
// Streams a run of words out of a synchronous data memory as valid/ready
// beats. A dump is requested with start (sampled only while idle) and walks
// wordCount words from firstAddress, wrapping modulo 2**ADDR_WIDTH. The count
// is clamped to one full pass over the memory.
//
// Optional feature: define DUMP_CHECKSUM_EN to append a final beat carrying
// the XOR of all emitted data words (outAddress 0, outLast 1).
//
// Ports:
//   clock, resetMachine   clock and asynchronous active-low reset
//   start                 dump request (ignored while busy)
//   firstAddress          first word address, sampled with start
//   wordCount             number of words, sampled with start
//   busy, done            activity flag and one-cycle completion pulse
//   memReadEnable         read strobe to the data memory
//   memAddress            read address to the data memory
//   memReadData           read data, valid the cycle after the strobe
//   outValid, outReady    output beat handshake
//   outAddress, outData   address and contents of the word in the beat
//   outLast               marks the final beat of a dump
module data_memory_dumper #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetMachine,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] firstAddress,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  memReadEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0] memReadData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDR_WIDTH-1:0] outAddress,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outLast
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
`ifdef DUMP_CHECKSUM_EN
    ST_CHECK = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

  // One full pass over the memory is the most a single dump can emit.
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_COUNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH:0]   count_r;       // words still to emit, including the current one
  logic [ADDR_WIDTH:0]   count_clamped_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic                  last_word_s;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_r;

  // Running checksum update: plain XOR fold of one more word.
  function automatic logic [DATA_WIDTH-1:0] fold_checksum(
    input logic [DATA_WIDTH-1:0] sum,
    input logic [DATA_WIDTH-1:0] word
  );
    return sum ^ word;
  endfunction
`endif

  assign count_clamped_s = (wordCount > MAX_COUNT) ? MAX_COUNT : wordCount;
  assign next_addr_s     = addr_r + 1'b1;   // natural wrap at 2**ADDR_WIDTH
  assign last_word_s     = (count_r == ONE_COUNT);

  // Dump sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge resetMachine) begin
    if (!resetMachine) begin
      state_r       <= ST_IDLE;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      count_r       <= {(ADDR_WIDTH+1){1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      memReadEnable <= 1'b0;
      memAddress    <= {ADDR_WIDTH{1'b0}};
      outValid      <= 1'b0;
      outAddress    <= {ADDR_WIDTH{1'b0}};
      outData       <= {DATA_WIDTH{1'b0}};
      outLast       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      checksum_r    <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_r  <= firstAddress;
            count_r <= count_clamped_s;
            busy    <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            checksum_r <= {DATA_WIDTH{1'b0}};
`endif
            if (count_clamped_s != {(ADDR_WIDTH+1){1'b0}}) begin
              state_r       <= ST_READ;
              memReadEnable <= 1'b1;
              memAddress    <= firstAddress;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              // Empty dump still emits the (zero) checksum as its only beat.
              state_r    <= ST_CHECK;
              outValid   <= 1'b1;
              outData    <= {DATA_WIDTH{1'b0}};
              outAddress <= {ADDR_WIDTH{1'b0}};
              outLast    <= 1'b1;
`else
              state_r <= ST_DONE;
              done    <= 1'b1;
`endif
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ST_READ: begin
          // Strobe lasts exactly this one cycle; data returns during WAIT.
          memReadEnable <= 1'b0;
          state_r       <= ST_WAIT;
        end

        ST_WAIT: begin
          outData    <= memReadData;
          outAddress <= addr_r;
          outValid   <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          outLast    <= 1'b0;
`else
          outLast    <= last_word_s;
`endif
          state_r    <= ST_SEND;
        end

        ST_SEND: begin
          // Beat is held untouched until the sink takes it.
          if (outReady) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum_r <= fold_checksum(checksum_r, outData);
`endif
            if (last_word_s) begin
`ifdef DUMP_CHECKSUM_EN
              state_r    <= ST_CHECK;
              outValid   <= 1'b1;
              outData    <= fold_checksum(checksum_r, outData);
              outAddress <= {ADDR_WIDTH{1'b0}};
              outLast    <= 1'b1;
`else
              state_r <= ST_DONE;
              done    <= 1'b1;
`endif
            end else begin
              addr_r        <= next_addr_s;
              count_r       <= count_r - ONE_COUNT;
              state_r       <= ST_READ;
              memReadEnable <= 1'b1;
              memAddress    <= next_addr_s;
            end
          end
        end

`ifdef DUMP_CHECKSUM_EN
        ST_CHECK: begin
          if (outReady) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            state_r  <= ST_DONE;
            done     <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r       <= ST_IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
          memReadEnable <= 1'b0;
          outValid      <= 1'b0;
          outLast       <= 1'b0;
        end
      endcase
    end
  end

endmodule
